ram_burst_ctrl: RTL and testbench

Burst master that sits directly upstream of the 32x32 single-port ram. It converts a start/base/length command plus valid/ready data streams into the ram's cen/wen/addr/din strobes, and returns read words through a small FIFO.
It is the only driver of the ram ports in the Top design. Write bursts consume a stream; read bursts produce a stream with backpressure.

---
 rtl/ram_burst_ctrl.sv | 139 +++++++++++++
 tb/tb_ram_burst_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst master for a 32x32 single-port ram: turns start/base/len commands plus
// valid/ready streams into registered ram strobes, returning read words via a FIFO.
module ram_burst_ctrl #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int FD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          M_cen,
    output logic          M_wen,
    output logic [AW-1:0] M_addr,
    output logic [DW-1:0] M_din,
    input  logic [DW-1:0] M_dout
);

    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t        state_q;
    logic [AW-1:0] cur_q;
    logic [AW:0]   rem_q;
    logic          cen_q, wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic          rv1_q, rv2_q;
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] fifo_q [FD];

    logic wr_hs, issue, push, pop, credit_ok;

    // Credit counts words already queued plus reads still in the 2-edge ram pipe.
    assign credit_ok = (int'(cnt_q) + int'(rv1_q) + int'(rv2_q)) < FD;
    assign issue     = (state_q == READ) && credit_ok;
    assign wr_hs     = (state_q == WRITE) && wr_valid;
    assign push      = rv2_q;
    assign pop       = rd_ready && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wp_q] <= M_dout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            cen_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rv1_q   <= 1'b0;
            rv2_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            cen_q <= 1'b0;
            wen_q <= 1'b0;
            rv1_q <= issue;
            rv2_q <= rv1_q;
            cnt_q <= cnt_d;
            if (push) wp_q <= (wp_q == PW'(FD - 1)) ? '0 : wp_q + PW'(1);
            if (pop)  rp_q <= (rp_q == PW'(FD - 1)) ? '0 : rp_q + PW'(1);

            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_q <= base_addr;
                        rem_q <= len;
                        if (len == '0)  state_q <= DONE;
                        else if (mode)  state_q <= WRITE;
                        else            state_q <= READ;
                    end
                end
                WRITE: begin
                    if (wr_hs) begin
                        cen_q  <= 1'b1;
                        wen_q  <= 1'b1;
                        addr_q <= cur_q;
                        din_q  <= wr_data;
                        cur_q  <= cur_q + AW'(1);
                        rem_q  <= rem_q - (AW+1)'(1);
                        if (rem_q == (AW+1)'(1)) state_q <= DONE;
                    end
                end
                READ: begin
                    if (issue) begin
                        cen_q  <= 1'b1;
                        addr_q <= cur_q;
                        cur_q  <= cur_q + AW'(1);
                        rem_q  <= rem_q - (AW+1)'(1);
                        if (rem_q == (AW+1)'(1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!rv1_q && !rv2_q && cnt_q == '0) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign wr_ready = (state_q == WRITE);
    assign M_cen    = cen_q;
    assign M_wen    = wen_q;
    assign M_addr   = addr_q;
    assign M_din    = din_q;
    assign rd_valid = (cnt_q != '0);
    assign rd_data  = rd_valid ? fifo_q[rp_q] : '0;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural single-port ram model.
module tb_ram_burst_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, mode;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy, done;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready;
    logic          M_cen, M_wen;
    logic [AW-1:0] M_addr;
    logic [DW-1:0] M_din, M_dout;

    always #5 clk = ~clk;

    ram_burst_ctrl #(.AW(AW), .DW(DW), .FD(FD)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .len(len), .busy(busy), .done(done),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .M_cen(M_cen), .M_wen(M_wen), .M_addr(M_addr), .M_din(M_din),
        .M_dout(M_dout)
    );

    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (M_cen) begin
            if (M_wen) ram[M_addr] <= M_din;
            else       M_dout <= ram[M_addr];
        end
    end

    int n_chk = 0, n_fail = 0;
    int done_cnt = 0, wr_strobes = 0, rd_issues = 0, rd_hs = 0, cen_cnt = 0;
    int wrun = 0, max_wrun = 0, rrun = 0, max_rrun = 0;
    logic [AW-1:0]    exp_wcur;
    logic [DW-1:0]    shadow [32];
    logic [AW+DW-1:0] wq [$];
    logic [AW-1:0]    raq [$];
    logic [DW-1:0]    rdq [$];
    logic [DW-1:0]    wdata [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (M_cen) cen_cnt++;
            if (M_cen && M_wen) begin
                wr_strobes++;
                wrun++;
                if (wrun > max_wrun) max_wrun = wrun;
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_strobe", {M_addr, M_din}, wq.pop_front());
            end else begin
                wrun = 0;
            end
            if (M_cen && !M_wen) begin
                rd_issues++;
                if (raq.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", M_addr, raq.pop_front());
            end
            if (!M_cen && M_wen) chk("wen_without_cen", M_wen, 0);
            if (wr_valid && wr_ready) begin
                wq.push_back({exp_wcur, wr_data});
                shadow[exp_wcur] = wr_data;
                exp_wcur = exp_wcur + AW'(1);
            end
            if (rd_valid && rd_ready) begin
                rd_hs++;
                rrun++;
                if (rrun > max_rrun) max_rrun = rrun;
                if (rdq.size() == 0) chk("rd_data_unexpected", 1, 0);
                else chk("rd_data", rd_data, rdq.pop_front());
            end else begin
                rrun = 0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic cmd(input logic m, input logic [AW-1:0] b, input logic [AW:0] l);
        int t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) chk("cmd_idle_timeout", 1, 0);
        if (m) exp_wcur = b;
        else begin
            for (int i = 0; i < int'(l); i++) begin
                raq.push_back(b + AW'(i));
                rdq.push_back(shadow[b + AW'(i)]);
            end
        end
        start = 1'b1; mode = m; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic inj);
        int t = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        if (inj) begin
            start = 1'b1; mode = 1'b0; len = 3; base_addr = '0;
        end
        @(negedge clk);
        while (!wr_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!wr_ready) chk("wr_ready_timeout", 0, 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] b, input logic inject);
        cmd(1'b1, b, (AW+1)'(wdata.size()));
        for (int i = 0; i < wdata.size(); i++) send_word(wdata[i], inject && i == 1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_count", done_cnt, target);
    endtask

    int dn = 0, iss0, hs0, c0, d0, ws0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, wr_ready, rd_valid, M_cen, M_wen, M_addr, M_din}, 0);
        chk("reset_rd_data", rd_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: write 1..4 at base 1, read back with rd_ready high
        max_wrun = 0;
        wdata = '{32'd1, 32'd2, 32'd3, 32'd4};
        write_burst(5'd1, 1'b0);
        wait_done(++dn);
        chk("t1_wr_run", max_wrun, 4);
        chk("t1_wq_empty", wq.size(), 0);
        max_rrun = 0;
        rd_ready = 1'b1;
        cmd(1'b0, 5'd1, 6'd4);
        wait_done(++dn);
        chk("t1_rd_run", max_rrun, 4);
        chk("t1_rdq_empty", rdq.size(), 0);

        // 2: wrap-around 30,31,0,1
        wdata = '{32'hA, 32'hB, 32'hC, 32'hD};
        write_burst(5'd30, 1'b0);
        wait_done(++dn);
        cmd(1'b0, 5'd30, 6'd4);
        wait_done(++dn);
        chk("t2_raq_empty", raq.size(), 0);
        chk("t2_rdq_empty", rdq.size(), 0);

        // 3: backpressure limits outstanding reads to FD
        wdata.delete();
        for (int i = 0; i < 8; i++) wdata.push_back(32'h100 + i);
        write_burst(5'd8, 1'b0);
        wait_done(++dn);
        rd_ready = 1'b0;
        iss0 = rd_issues; hs0 = rd_hs;
        cmd(1'b0, 5'd8, 6'd8);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_issued", rd_issues - iss0, FD);
        chk("t3_cen_stalled", M_cen, 0);
        chk("t3_rd_valid", rd_valid, 1);
        chk("t3_head", rd_data, 32'h100);
        rd_ready = 1'b1;
        wait_done(++dn);
        chk("t3_handshakes", rd_hs - hs0, 8);
        chk("t3_rdq_empty", rdq.size(), 0);

        // 4: zero-length burst
        c0 = cen_cnt;
        cmd(1'b0, 5'd3, 6'd0);
        chk("t4_done_pulse", done, 1);
        @(posedge clk); #1;
        chk("t4_busy_cleared", busy, 0);
        wait_done(++dn);
        chk("t4_no_cen", cen_cnt, c0);

        // 5: reset after 2 of 5 words
        cmd(1'b1, 5'd0, 6'd5);
        send_word(32'hDEAD0000, 1'b0);
        send_word(32'hBEEF0001, 1'b0);
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_wq_empty", wq.size(), 0);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("t5_reset_outputs", {busy, done, wr_ready, rd_valid, M_cen, M_wen, M_addr, M_din}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        wq.delete(); raq.delete(); rdq.delete();
        @(posedge clk); #1;
        chk("t5_no_done", done_cnt, d0);
        cmd(1'b0, 5'd0, 6'd2);
        wait_done(++dn);
        chk("t5_rdq_empty", rdq.size(), 0);

        // 6: start during a write burst is ignored
        ws0 = wr_strobes; iss0 = rd_issues;
        wdata = '{32'h600, 32'h601, 32'h602, 32'h603};
        write_burst(5'd12, 1'b1);
        wait_done(++dn);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_single_done", done_cnt, dn);
        chk("t6_idle", busy, 0);
        chk("t6_wr_strobes", wr_strobes - ws0, 4);
        chk("t6_no_reads", rd_issues - iss0, 0);
        chk("t6_wq_empty", wq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
